// File: rtl/time_to_mili.sv
// time_to_mili
// Converts an hours/minutes/seconds/milliseconds time value into a single
// millisecond count for the stopwatch/alarm datapath. The multiplies use
// bit-serial shift-add with fixed constants:
//   hours   * 3600000
//   minutes * 60000
//   seconds * 1000
// Milliseconds are then added. Latency is fixed: with start sampled at edge E0,
// outValid is high in the cycle after edge E0 + 3*FIELD_W + 2.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous, active-high reset
//   start        conversion request, sampled only while busy = 0
//   inputHours   hours field        (FIELD_W)
//   inputMinutes minutes field      (FIELD_W)
//   inputSec     seconds field      (FIELD_W)
//   inputMili    milliseconds field (FIELD_W)
//   outputMili   registered result (OUT_W), held until the next result
//   outValid     one-cycle pulse, asserted in the cycle outputMili updates
//   busy         high while a conversion is in progress
//   rangeErr     out-of-range flag, registered alongside outputMili
//
// Optional feature, macro RANGE_CHECK_EN
//   Defined:   rangeErr reports whether minutes >= 60, seconds >= 60 or
//              milliseconds >= 1000 for the request just completed.
//   Undefined: no compare logic is built and rangeErr is tied to 0.
//
// OUT_W must be at least FIELD_W + 22. This keeps the largest shifted hours
// constant and the full sum within OUT_W.

module time_to_mili #(
  parameter int FIELD_W = 22,
  parameter int OUT_W   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [FIELD_W-1:0] inputHours,
  input  logic [FIELD_W-1:0] inputMinutes,
  input  logic [FIELD_W-1:0] inputSec,
  input  logic [FIELD_W-1:0] inputMili,
  output logic [OUT_W-1:0]   outputMili,
  output logic               outValid,
  output logic               busy,
  output logic               rangeErr
);

  localparam int BIT_W = (FIELD_W > 1) ? $clog2(FIELD_W) : 1;

  // state | meaning
  // IDLE  | waiting for start; outputs hold the last result
  // MUL   | one operand bit per cycle, fields hours -> minutes -> seconds
  // ADDMS | add the latched milliseconds into the accumulator
  // DONE  | publish the accumulator, pulse outValid, drop busy
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    ADDMS = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [FIELD_W-1:0] min_q;
  logic [FIELD_W-1:0] sec_q;
  logic [FIELD_W-1:0] ms_q;
  logic [FIELD_W-1:0] op_sh;     // current operand, shifted right one bit per cycle
  logic [OUT_W-1:0]   acc;
  logic [OUT_W-1:0]   mcand;     // K[fld] << bitc, maintained by shifting
  logic [1:0]         fld;
  logic [BIT_W-1:0]   bitc;

  logic load;
  logic step;
  logic last_bit;
  logic last_fld;
  logic add_ms;
  logic finish;

  function automatic logic [OUT_W-1:0] k_of(input logic [1:0] f);
    case (f)
      2'd0:    k_of = OUT_W'(3600000);
      2'd1:    k_of = OUT_W'(60000);
      2'd2:    k_of = OUT_W'(1000);
      default: k_of = '0;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL;
      MUL:     if (last_bit && last_fld) state_nxt = ADDMS;
      ADDMS:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath control decode
  always_comb begin
    load     = (state == IDLE) && start;
    step     = (state == MUL);
    last_bit = (bitc == BIT_W'(FIELD_W - 1));
    last_fld = (fld == 2'd2);
    add_ms   = (state == ADDMS);
    finish   = (state == DONE);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q      <= '0;
      sec_q      <= '0;
      ms_q       <= '0;
      op_sh      <= '0;
      acc        <= '0;
      mcand      <= '0;
      fld        <= '0;
      bitc       <= '0;
      outputMili <= '0;
      outValid   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      outValid <= 1'b0;

      if (load) begin
        op_sh <= inputHours;
        min_q <= inputMinutes;
        sec_q <= inputSec;
        ms_q  <= inputMili;
        acc   <= '0;
        fld   <= 2'd0;
        bitc  <= '0;
        mcand <= k_of(2'd0);
        busy  <= 1'b1;
      end

      if (step) begin
        if (op_sh[0]) begin
          acc <= acc + mcand;
        end
        if (last_bit) begin
          // Move to the next field. After seconds, op_sh and mcand are not used again.
          bitc  <= '0;
          fld   <= fld + 2'd1;
          mcand <= k_of(fld + 2'd1);
          op_sh <= (fld == 2'd0) ? min_q : sec_q;
        end else begin
          bitc  <= bitc + BIT_W'(1);
          mcand <= mcand << 1;
          op_sh <= op_sh >> 1;
        end
      end

      if (add_ms) begin
        acc <= acc + {{(OUT_W - FIELD_W){1'b0}}, ms_q};
      end

      if (finish) begin
        outputMili <= acc;
        outValid   <= 1'b1;
        busy       <= 1'b0;
      end
    end
  end

`ifdef RANGE_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q    <= 1'b0;
      rangeErr <= 1'b0;
    end else begin
      if (load) begin
        err_q <= (inputMinutes >= FIELD_W'(60)) |
                 (inputSec     >= FIELD_W'(60)) |
                 (inputMili    >= FIELD_W'(1000));
      end
      if (finish) begin
        rangeErr <= err_q;
      end
    end
  end
`else
  assign rangeErr = 1'b0;
`endif

endmodule

// File: tb/tb_time_to_mili.sv
module tb_time_to_mili;

  localparam int FW  = 22;
  localparam int OW  = 64;
  localparam int LAT = 3 * FW + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [FW-1:0] inputHours;
  logic [FW-1:0] inputMinutes;
  logic [FW-1:0] inputSec;
  logic [FW-1:0] inputMili;
  logic [OW-1:0] outputMili;
  logic          outValid;
  logic          busy;
  logic          rangeErr;

  time_to_mili #(.FIELD_W(FW), .OUT_W(OW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .inputHours   (inputHours),
    .inputMinutes (inputMinutes),
    .inputSec     (inputSec),
    .inputMili    (inputMili),
    .outputMili   (outputMili),
    .outValid     (outValid),
    .busy         (busy),
    .rangeErr     (rangeErr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [63:0] v;
    logic        e;
    int          c;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  logic bad_busy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic err_model(input logic e_en);
`ifdef RANGE_CHECK_EN
    return e_en;
`else
    return 1'b0 & e_en;
`endif
  endfunction

  // Monitor: pops one expectation per outValid pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (outValid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got outputMili=%0d with no request pending", outputMili);
        end else begin
          m_e = q.pop_front();
          chk("outputMili", outputMili, m_e.v);
          chk("rangeErr", {63'd0, rangeErr}, {63'd0, m_e.e});
          chk("latency_cycle", 64'(cyc), 64'(m_e.c));
          chk("busy_at_valid", {63'd0, busy}, 64'd0);
          chk("busy_held", {63'd0, bad_busy}, 64'd0);
          bad_busy = 1'b0;
        end
      end else if (q.size() > 0 && !busy) begin
        bad_busy = 1'b1;
      end
    end
  end

  // Call at a negedge with busy low. Returns at the negedge after the accept edge.
  task automatic issue(input logic [FW-1:0] h, input logic [FW-1:0] m,
                       input logic [FW-1:0] s, input logic [FW-1:0] ms,
                       input logic [63:0] v, input logic e_en);
    exp_t t;
    inputHours   = h;
    inputMinutes = m;
    inputSec     = s;
    inputMili    = ms;
    start        = 1'b1;
    @(posedge clk);
    #1;
    t.v = v;
    t.e = err_model(e_en);
    t.c = cyc + LAT;
    q.push_back(t);
    @(negedge clk);
    start        = 1'b0;
    inputHours   = 22'h2AAAAA;
    inputMinutes = 22'h155555;
    inputSec     = 22'h3FFFFF;
    inputMili    = 22'h123456;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout_drain: got %0d results pending, expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!outValid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!outValid) begin
      checks++;
      errors++;
      $display("FAIL timeout_valid: got outValid=0, expected 1");
    end
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    inputHours   = '0;
    inputMinutes = '0;
    inputSec     = '0;
    inputMili    = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputMili", outputMili, 64'd0);
    chk("reset_outValid", {63'd0, outValid}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_rangeErr", {63'd0, rangeErr}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic conversions and boundary values.
    issue(22'd1, 22'd2, 22'd3, 22'd4, 64'd3723004, 1'b0);
    wait_drain();
    issue(22'd23, 22'd59, 22'd59, 22'd999, 64'd86399999, 1'b0);
    wait_drain();
    issue(22'd0, 22'd0, 22'd0, 22'd0, 64'd0, 1'b0);
    wait_drain();
    issue(22'd4194303, 22'd0, 22'd0, 22'd0, 64'd15099490800000, 1'b0);
    wait_drain();
    issue(22'd0, 22'd90, 22'd0, 22'd0, 64'd5400000, 1'b1);
    wait_drain();

    // A start while busy is ignored. A start during outValid is accepted.
    issue(22'd0, 22'd0, 22'd0, 22'd500, 64'd500, 1'b0);
    repeat (8) @(negedge clk);
    inputHours = 22'd5; inputMinutes = 22'd5; inputSec = 22'd5; inputMili = 22'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid();
    issue(22'd2, 22'd0, 22'd0, 22'd7, 64'd7200007, 1'b0);
    wait_drain();

    // Reset aborts an in-flight conversion.
    issue(22'd3, 22'd3, 22'd3, 22'd3, 64'd10983003, 1'b0);
    repeat (28) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    chk("abort_outputMili", outputMili, 64'd0);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_outValid", {63'd0, outValid}, 64'd0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    issue(22'd0, 22'd0, 22'd1, 22'd0, 64'd1000, 1'b0);
    wait_drain();

    // Range flag boundaries.
    issue(22'd0, 22'd60, 22'd0, 22'd0, 64'd3600000, 1'b1);
    wait_drain();
    repeat (5) @(negedge clk);
    chk("rangeErr_hold", {63'd0, rangeErr}, {63'd0, err_model(1'b1)});
    issue(22'd0, 22'd59, 22'd0, 22'd0, 64'd3540000, 1'b0);
    wait_drain();
    issue(22'd0, 22'd0, 22'd60, 22'd0, 64'd60000, 1'b1);
    wait_drain();
    issue(22'd0, 22'd0, 22'd59, 22'd999, 64'd59999, 1'b0);
    wait_drain();
    issue(22'd0, 22'd0, 22'd0, 22'd1000, 64'd1000, 1'b1);
    wait_drain();

    repeat (100) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
